// File: rtl/mms_sample_loader_pkg.sv
// Shared definitions for the max/min selector front end.
// Holds the sample width, the group size, the select-bit meaning
// used by the downstream selector, and the bank identifier type
// used for the ping-pong read and write pointers.
package mms_sample_loader_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM    = 8;
    localparam int unsigned IDX_W  = $clog2(NUM);

    localparam logic SEL_MIN = 1'b1;
    localparam logic SEL_MAX = 1'b0;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/mms_sample_loader_bank.sv
// One group buffer: NUM samples of DATA_W bits plus the select bit
// of the group. Written one sample at a time through an indexed port,
// read out as a flat vector (sample i at bits [i*DATA_W +: DATA_W]).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_we         write enable for the sample at i_widx
//   i_widx       sample index to write
//   i_wdata      sample value
//   i_wsel_en    also load the select register on this write
//   i_wsel       select bit value
//   o_data       all NUM samples, flattened
//   o_sel        stored select bit
module mms_sample_loader_bank
    import mms_sample_loader_pkg::*;
#(
    parameter int unsigned DATA_W = mms_sample_loader_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_wsel_en,
    input  logic                  i_wsel,
    output logic [NUM*DATA_W-1:0] o_data,
    output logic                  o_sel
);

    logic [DATA_W-1:0] r_mem [NUM];
    logic              r_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                r_mem[i] <= '0;
            end
            r_sel <= 1'b0;
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
            if (i_wsel_en) begin
                r_sel <= i_wsel;
            end
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_flat
        assign o_data[g*DATA_W +: DATA_W] = r_mem[g];
    end

    assign o_sel = r_sel;

endmodule

// File: rtl/mms_sample_loader.sv
// Serial-to-parallel front end for the 8-number max/min selector.
// Accepts one sample per cycle, collects groups of NUM samples into
// two ping-pong banks and presents the oldest complete group on
// number0..number7 with its select bit. Upstream stalls only when
// both banks hold complete groups.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear                 synchronous flush of buffered groups
//   in_valid/in_ready     sample handshake
//   in_data, in_select    sample and select bit (select taken at index 0)
//   out_valid/out_ready   group handshake
//   out_select            select bit of the presented group
//   number0..number7      presented group, in arrival order
//   fill_cnt              samples already in the write bank
module mms_sample_loader
    import mms_sample_loader_pkg::*;
#(
    parameter int unsigned DATA_W = mms_sample_loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_select,
    output logic [DATA_W-1:0] number0,
    output logic [DATA_W-1:0] number1,
    output logic [DATA_W-1:0] number2,
    output logic [DATA_W-1:0] number3,
    output logic [DATA_W-1:0] number4,
    output logic [DATA_W-1:0] number5,
    output logic [DATA_W-1:0] number6,
    output logic [DATA_W-1:0] number7,
    output logic [3:0]        fill_cnt
);

    bank_t            r_wr_sel;
    bank_t            r_rd_sel;
    logic [IDX_W-1:0] r_wr_idx;
    logic [1:0]       r_full;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_release;
    logic [1:0]            w_full_nxt;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_sel_en;
    logic [NUM*DATA_W-1:0] w_data_a;
    logic [NUM*DATA_W-1:0] w_data_b;
    logic                  w_sel_a;
    logic                  w_sel_b;
    logic [NUM*DATA_W-1:0] w_rd_data;

    // in_ready depends only on registered state, so out_ready never
    // reaches it combinationally.
    assign in_ready   = !r_full[r_wr_sel];
    assign out_valid  = r_full[r_rd_sel];

    // clear wins over both handshakes in the same cycle.
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_complete = w_accept && (r_wr_idx == IDX_W'(NUM - 1));
    assign w_release  = out_valid && out_ready && !clear;

    assign w_sel_en   = (r_wr_idx == '0);
    assign w_we_a     = w_accept && (r_wr_sel == BANK_A);
    assign w_we_b     = w_accept && (r_wr_sel == BANK_B);

    // Completion and release always address different banks: release
    // needs full[rd_sel] set, completion needs full[wr_sel] clear.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
        if (w_complete) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_sel <= BANK_A;
            r_rd_sel <= BANK_A;
            r_wr_idx <= '0;
            r_full   <= '0;
        end else if (clear) begin
            r_wr_sel <= BANK_A;
            r_rd_sel <= BANK_A;
            r_wr_idx <= '0;
            r_full   <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_complete) begin
                r_wr_sel <= other_bank(r_wr_sel);
            end
            if (w_release) begin
                r_rd_sel <= other_bank(r_rd_sel);
            end
        end
    end

    mms_sample_loader_bank #(
        .DATA_W (DATA_W)
    ) u_bank_a (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we_a),
        .i_widx    (r_wr_idx),
        .i_wdata   (in_data),
        .i_wsel_en (w_sel_en),
        .i_wsel    (in_select),
        .o_data    (w_data_a),
        .o_sel     (w_sel_a)
    );

    mms_sample_loader_bank #(
        .DATA_W (DATA_W)
    ) u_bank_b (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we_b),
        .i_widx    (r_wr_idx),
        .i_wdata   (in_data),
        .i_wsel_en (w_sel_en),
        .i_wsel    (in_select),
        .o_data    (w_data_b),
        .o_sel     (w_sel_b)
    );

    assign w_rd_data  = (r_rd_sel == BANK_B) ? w_data_b : w_data_a;
    assign out_select = (r_rd_sel == BANK_B) ? w_sel_b  : w_sel_a;

    assign number0 = w_rd_data[0*DATA_W +: DATA_W];
    assign number1 = w_rd_data[1*DATA_W +: DATA_W];
    assign number2 = w_rd_data[2*DATA_W +: DATA_W];
    assign number3 = w_rd_data[3*DATA_W +: DATA_W];
    assign number4 = w_rd_data[4*DATA_W +: DATA_W];
    assign number5 = w_rd_data[5*DATA_W +: DATA_W];
    assign number6 = w_rd_data[6*DATA_W +: DATA_W];
    assign number7 = w_rd_data[7*DATA_W +: DATA_W];

    assign fill_cnt = 4'(r_wr_idx);

endmodule
